// File: rtl/key_event_queue.sv
// key_event_queue
//   Converts decoder make codes into a buffered stream of key-press events and
//   adds typematic auto-repeat for the most recently pressed key that is still
//   held. Events leave through a first-word-fall-through FIFO.
//
// Handshake: the head entry is offered while evt_valid=1 and is consumed on
//   any cycle where evt_valid & evt_ready are both high. evt_* stay stable
//   until that cycle. When the FIFO is empty, evt_* keep the last consumed
//   entry (0 after reset).
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   key_valid     1-cycle pulse per decoder make/break
//   key_code      9-bit scan code, qualified by key_valid
//   key_pressed   1 = make, 0 = break
//   shift_down    left or right shift currently held
//   repeat_en     1 = auto-repeat enabled
//   evt_valid     head entry available
//   evt_ready     consumer accepts head
//   evt_code      head scan code
//   evt_shift     shift_down captured at push
//   evt_repeat    1 = auto-repeat entry, 0 = real make
//   overflow      sticky, a push was dropped because the FIFO was full
//   count         entries held
module key_event_queue #(
  parameter int DEPTH     = 8,
  parameter int DELAY_CYC = 50_000_000,
  parameter int RATE_CYC  = 10_000_000,
  parameter int CNT_W     = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     key_valid,
  input  logic [8:0]               key_code,
  input  logic                     key_pressed,
  input  logic                     shift_down,
  input  logic                     repeat_en,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [8:0]               evt_code,
  output logic                     evt_shift,
  output logic                     evt_repeat,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_CYC - 1);
  localparam logic [CW-1:0]    FULL_CNT   = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } trk_state_t;

  // ---------------- input qualification ----------------
  logic is_shift;
  logic make_evt;
  logic brk_held;

  assign is_shift = (key_code == 9'h012) || (key_code == 9'h059);
  assign make_evt = key_valid & key_pressed & ~is_shift;

  // ---------------- repeat tracker ----------------
  trk_state_t       state_q, state_d;
  logic [8:0]       held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  assign brk_held = key_valid & ~key_pressed & ~is_shift & (key_code == held_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      held_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    cnt_d   = cnt_q;
    tick    = 1'b0;
    case (state_q)
      ST_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          tick    = 1'b1;
          cnt_d   = '0;
          state_d = ST_REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (cnt_q == RATE_LAST) begin
          tick  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase

    // Releasing the held key stops repeating; a tick landing on the same
    // cycle is discarded since the key is no longer down.
    if (brk_held) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      tick    = 1'b0;
    end

    // Newest key always takes over. Its own make entry occupies the single
    // FIFO write slot, so a coincident tick is dropped.
    if (make_evt) begin
      tick = 1'b0;
      if (repeat_en) begin
        held_d  = key_code;
        cnt_d   = '0;
        state_d = ST_DELAY;
      end
    end

    if (!repeat_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      tick    = 1'b0;
    end
  end

  // ---------------- FIFO ----------------
  // Entry layout: {shift, repeat, code[8:0]}
  logic [10:0]   mem [DEPTH];
  logic [10:0]   push_data;
  logic [10:0]   last_head;
  logic [10:0]   head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_fifo;
  logic          push_req, do_push, do_pop, full;

  assign push_req  = make_evt | tick;
  assign push_data = make_evt ? {shift_down, 1'b0, key_code}
                              : {shift_down, 1'b1, held_q};
  assign full      = (cnt_fifo == FULL_CNT);
  assign do_pop    = evt_valid & evt_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts.
  assign do_push   = push_req & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt_fifo  <= '0;
      overflow  <= 1'b0;
      last_head <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_head <= mem[rd_ptr];
      end
      if (push_req & ~do_push) overflow <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_fifo <= cnt_fifo + 1'b1;
        2'b01:   cnt_fifo <= cnt_fifo - 1'b1;
        default: cnt_fifo <= cnt_fifo;
      endcase
    end
  end

  assign evt_valid  = (cnt_fifo != '0);
  assign head       = evt_valid ? mem[rd_ptr] : last_head;
  assign evt_code   = head[8:0];
  assign evt_repeat = head[9];
  assign evt_shift  = head[10];
  assign count      = cnt_fifo;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with DEPTH=4, DELAY_CYC=10, RATE_CYC=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_key_event_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [8:0] key_code = '0;
  logic       key_pressed = 1'b0;
  logic       shift_down = 1'b0;
  logic       repeat_en = 1'b0;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [8:0] evt_code;
  logic       evt_shift;
  logic       evt_repeat;
  logic       overflow;
  logic [2:0] count;

  int n_vec = 0;
  int n_err = 0;
  int seen;
  logic [8:0] exp_q[$];
  logic [8:0] fill_a[4];
  logic [8:0] fill_b[5];

  key_event_queue #(
    .DEPTH(DEPTH), .DELAY_CYC(10), .RATE_CYC(4), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_code(key_code), .key_pressed(key_pressed),
    .shift_down(shift_down), .repeat_en(repeat_en),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_shift(evt_shift), .evt_repeat(evt_repeat),
    .overflow(overflow), .count(count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".valid"},    16'(evt_valid),  16'd0);
    check({tag, ".code"},     16'(evt_code),   16'd0);
    check({tag, ".shift"},    16'(evt_shift),  16'd0);
    check({tag, ".repeat"},   16'(evt_repeat), 16'd0);
    check({tag, ".overflow"}, 16'(overflow),   16'd0);
    check({tag, ".count"},    16'(count),      16'd0);
  endtask

  // ---------------- drivers (call on a falling edge) ----------------
  task automatic key_evt(input logic [8:0] code, input logic pressed, input logic shift);
    key_valid   = 1'b1;
    key_code    = code;
    key_pressed = pressed;
    shift_down  = shift;
    @(negedge clk);
    key_valid   = 1'b0;
  endtask

  task automatic drain_expected(input string tag);
    evt_ready = 1'b1;
    while (exp_q.size() != 0) begin
      check({tag, ".valid"}, 16'(evt_valid), 16'd1);
      check({tag, ".code"},  16'(evt_code),  16'(exp_q.pop_front()));
      @(negedge clk);
    end
    check({tag, ".empty"}, 16'(count), 16'd0);
  endtask

  initial begin
    fill_a = '{9'h015, 9'h01D, 9'h024, 9'h02D};
    fill_b = '{9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E};

    // ---- reset ----
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // ---- single make, consumer ready ----
    evt_ready = 1'b1;
    key_evt(9'h01C, 1'b1, 1'b0);
    check("make.valid",  16'(evt_valid),  16'd1);
    check("make.code",   16'(evt_code),   16'h01C);
    check("make.shift",  16'(evt_shift),  16'd0);
    check("make.repeat", 16'(evt_repeat), 16'd0);
    @(negedge clk);
    check("make.popped", 16'(count),      16'd0);
    check("make.hold",   16'(evt_code),   16'h01C);
    key_evt(9'h01C, 1'b0, 1'b0);

    // ---- hold with auto-repeat: entries at +10, +14, +18 ----
    repeat_en = 1'b1;
    key_evt(9'h01C, 1'b1, 1'b0);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      check($sformatf("rep.valid@%0d", k), 16'(evt_valid),
            16'((k == 10) || (k == 14) || (k == 18)));
      if (k == 10) begin
        check("rep.code",   16'(evt_code),   16'h01C);
        check("rep.repeat", 16'(evt_repeat), 16'd1);
      end
    end
    key_evt(9'h01C, 1'b0, 1'b0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (evt_valid) seen++;
    end
    check("rep.after_break", 16'(seen), 16'd0);

    // ---- shift make is swallowed, shift captured on next make ----
    repeat_en = 1'b0;
    key_evt(9'h012, 1'b1, 1'b1);
    check("shift.no_push", 16'(count), 16'd0);
    key_evt(9'h01C, 1'b1, 1'b1);
    check("shift.valid",  16'(evt_valid),  16'd1);
    check("shift.code",   16'(evt_code),   16'h01C);
    check("shift.shift",  16'(evt_shift),  16'd1);
    check("shift.repeat", 16'(evt_repeat), 16'd0);
    @(negedge clk);
    check("shift.count", 16'(count), 16'd0);
    key_evt(9'h01C, 1'b0, 1'b1);
    key_evt(9'h012, 1'b0, 1'b0);

    // ---- full FIFO, push and pop in the same cycle ----
    evt_ready = 1'b0;
    foreach (fill_a[i]) begin
      key_evt(fill_a[i], 1'b1, 1'b0);
      exp_q.push_back(fill_a[i]);
    end
    check("pp.full", 16'(count), 16'd4);
    key_valid = 1'b1; key_code = 9'h02C; key_pressed = 1'b1; evt_ready = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; evt_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(9'h02C);
    check("pp.count",    16'(count),    16'd4);
    check("pp.overflow", 16'(overflow), 16'd0);
    check("pp.head",     16'(evt_code), 16'h01D);
    drain_expected("pp.drain");

    // ---- overflow with consumer stalled ----
    evt_ready = 1'b0;
    foreach (fill_b[i]) begin
      key_evt(fill_b[i], 1'b1, 1'b0);
      if (exp_q.size() < DEPTH) exp_q.push_back(fill_b[i]);
    end
    check("ovf.count",    16'(count),    16'd4);
    check("ovf.overflow", 16'(overflow), 16'd1);
    drain_expected("ovf.drain");
    check("ovf.sticky", 16'(overflow), 16'd1);

    // ---- newest key wins, stale break ignored, reset mid-hold ----
    repeat_en = 1'b1;
    evt_ready = 1'b1;
    key_evt(9'h01C, 1'b1, 1'b0);            // captured at edge 0
    repeat (3) @(negedge clk);
    key_evt(9'h032, 1'b1, 1'b0);            // captured at edge 4
    check("new.code",   16'(evt_code),   16'h032);
    check("new.repeat", 16'(evt_repeat), 16'd0);
    key_evt(9'h01C, 1'b0, 1'b0);            // captured at edge 5
    for (int e = 6; e <= 18; e++) begin
      @(negedge clk);
      if (e == 13) check("new.no_early", 16'(count), 16'd0);
      if (e == 14) begin
        check("new.rep_valid",  16'(evt_valid),  16'd1);
        check("new.rep_code",   16'(evt_code),   16'h032);
        check("new.rep_repeat", 16'(evt_repeat), 16'd1);
        evt_ready = 1'b0;
      end
    end
    check("new.second_rep", 16'(count), 16'd2);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    evt_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (evt_valid) seen++;
    end
    check("midrst.no_repeat", 16'(seen), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
